// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes, selects.
// Latency: n/a (constants, types and one helper function only).
// Backpressure: n/a.
package mc_ctrl_pkg;

    // State codes are visible on the debug port, so their values are fixed.
    typedef enum logic [3:0] {
        RST_S     = 4'd0,
        FETCH     = 4'd1,
        DECODE    = 4'd2,
        MEM_ADDR  = 4'd3,
        MEM_READ  = 4'd4,
        MEM_WB    = 4'd5,
        MEM_WRITE = 4'd6,
        EXECUTE   = 4'd7,
        ALU_WB    = 4'd8,
        BRANCH    = 4'd9,
        JUMP      = 4'd10,
        ADDI_EX   = 4'd11,
        ADDI_WB   = 4'd12
    } ctrlState_t;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b00_0000;
    localparam logic [5:0] OP_LW    = 6'b10_0011;
    localparam logic [5:0] OP_SW    = 6'b10_1011;
    localparam logic [5:0] OP_BEQ   = 6'b00_0100;
    localparam logic [5:0] OP_ADDI  = 6'b00_1000;
    localparam logic [5:0] OP_J     = 6'b00_0010;

    // lw and sw differ only in bit 3; this bit is held from DECODE to MEM_ADDR.
    localparam int OP_STORE_BIT = 3;

    // ALUOp into the ALU control block
    localparam logic [1:0] ALU_RTYPE = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_ADD   = 2'b10;

    // ALU operand B select
    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // States that occupy the memory port and therefore stretch to the memory latency.
    function automatic logic isMemState(input ctrlState_t s);
        return (s == FETCH) || (s == MEM_READ) || (s == MEM_WRITE);
    endfunction

endpackage

// File: rtl/mc_wait_counter.sv
// Memory-wait counter: counts cycles spent in a memory state, flags the last one.
// Latency: last is combinational from the count register; count updates each clock.
// Backpressure: none; clear has priority over enable.
module mc_wait_counter #(
    parameter int LATENCY = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic last
);

    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] LAST_VAL = CW'(LATENCY - 1);

    logic [CW-1:0] count;

    // Count up while enabled; clear returns to zero so every memory state starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CW'(1);
        end
    end

    assign last = (count == LAST_VAL);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back.
// Latency: Moore outputs from state and wait counter; illegal_op/instr_done in DECODE follow opcode.
// Backpressure: none; memory states simply dwell MEM_LATENCY cycles.
module multicycle_control #(
    parameter int MEM_LATENCY = 1,
    parameter int EXT_ISA     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       ALUSrcA,
    output logic       RegDst,
    output logic       RegWrite,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [1:0] ALUOp,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state
);

    import mc_ctrl_pkg::*;

    ctrlState_t stateQ;
    ctrlState_t nextState;
    logic       storeQ;
    logic       waitLast;
    logic       inMem;
    logic       decodeIllegal;

    assign inMem = isMemState(stateQ);

    // Counter restarts whenever we are outside a memory state or finishing one,
    // so it is always zero on the first cycle of the next memory state.
    mc_wait_counter #(
        .LATENCY(MEM_LATENCY)
    ) uWait (
        .clk   (clk),
        .rst   (rst),
        .clear (!inMem || waitLast),
        .enable(inMem),
        .last  (waitLast)
    );

    // State register; reset abandons any instruction in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= RST_S;
        end else begin
            stateQ <= nextState;
        end
    end

    // Remember lw vs sw at DECODE so MEM_ADDR does not depend on the live opcode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            storeQ <= 1'b0;
        end else if (stateQ == DECODE) begin
            storeQ <= opcode[OP_STORE_BIT];
        end
    end

    // Next-state selection and datapath control decode.
    always_comb begin
        nextState     = FETCH;
        decodeIllegal = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        IorD          = 1'b0;
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        MemtoReg      = 1'b0;
        IRWrite       = 1'b0;
        ALUSrcA       = 1'b0;
        RegDst        = 1'b0;
        RegWrite      = 1'b0;
        ALUSrcB       = SRCB_REG;
        PCSource      = PCSRC_ALU;
        ALUOp         = ALU_RTYPE;
        instr_done    = 1'b0;
        illegal_op    = 1'b0;

        case (stateQ)
            RST_S: begin
                nextState = FETCH;
            end

            FETCH: begin
                // PC+4 is computed every cycle; it and IR are committed only on the last one.
                MemRead  = 1'b1;
                ALUSrcB  = SRCB_FOUR;
                ALUOp    = ALU_ADD;
                PCSource = PCSRC_ALU;
                if (waitLast) begin
                    IRWrite   = 1'b1;
                    PCWrite   = 1'b1;
                    nextState = DECODE;
                end else begin
                    nextState = FETCH;
                end
            end

            DECODE: begin
                // Speculatively compute the branch target while decoding.
                ALUSrcB = SRCB_IMMSH;
                ALUOp   = ALU_ADD;
                case (opcode)
                    OP_RTYPE:     nextState = EXECUTE;
                    OP_LW, OP_SW: nextState = MEM_ADDR;
                    OP_BEQ:       nextState = BRANCH;
                    OP_J: begin
                        if (EXT_ISA != 0) nextState = JUMP;
                        else              decodeIllegal = 1'b1;
                    end
                    OP_ADDI: begin
                        if (EXT_ISA != 0) nextState = ADDI_EX;
                        else              decodeIllegal = 1'b1;
                    end
                    default:      decodeIllegal = 1'b1;
                endcase
                if (decodeIllegal) begin
                    nextState  = FETCH;
                    illegal_op = 1'b1;
                    instr_done = 1'b1;
                end
            end

            MEM_ADDR: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                ALUOp     = ALU_ADD;
                nextState = storeQ ? MEM_WRITE : MEM_READ;
            end

            MEM_READ: begin
                MemRead   = 1'b1;
                IorD      = 1'b1;
                nextState = waitLast ? MEM_WB : MEM_READ;
            end

            MEM_WB: begin
                RegWrite   = 1'b1;
                MemtoReg   = 1'b1;
                instr_done = 1'b1;
                nextState  = FETCH;
            end

            MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (waitLast) begin
                    instr_done = 1'b1;
                    nextState  = FETCH;
                end else begin
                    nextState = MEM_WRITE;
                end
            end

            EXECUTE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_REG;
                ALUOp     = ALU_RTYPE;
                nextState = ALU_WB;
            end

            ALU_WB: begin
                RegDst     = 1'b1;
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nextState  = FETCH;
            end

            BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUSrcB     = SRCB_REG;
                ALUOp       = ALU_SUB;
                PCWriteCond = 1'b1;
                PCSource    = PCSRC_ALUOUT;
                instr_done  = 1'b1;
                nextState   = FETCH;
            end

            JUMP: begin
                PCWrite    = 1'b1;
                PCSource   = PCSRC_JUMP;
                instr_done = 1'b1;
                nextState  = FETCH;
            end

            ADDI_EX: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = SRCB_IMM;
                ALUOp     = ALU_ADD;
                nextState = ADDI_WB;
            end

            ADDI_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
                nextState  = FETCH;
            end

            // Unused codes recover to FETCH with all controls inactive.
            default: begin
                nextState = FETCH;
            end
        endcase
    end

    assign state = stateQ;

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: three parameter sets, per-cycle scoreboard of every output.
`timescale 1ns/1ps
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcWrite;
        logic       pcWriteCond;
        logic       iorD;
        logic       memRead;
        logic       memWrite;
        logic       memtoReg;
        logic       irWrite;
        logic       aluSrcA;
        logic       regDst;
        logic       regWrite;
        logic [1:0] aluSrcB;
        logic [1:0] pcSource;
        logic [1:0] aluOp;
        logic       done;
        logic       ill;
    } obs_t;

    typedef struct packed {
        logic       rstIn;
        logic [5:0] opc;
        logic       randOpc;
        obs_t       exp;
    } step_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;

    logic       pcWriteA[3];
    logic       pcWriteCondA[3];
    logic       iorDA[3];
    logic       memReadA[3];
    logic       memWriteA[3];
    logic       memtoRegA[3];
    logic       irWriteA[3];
    logic       aluSrcAA[3];
    logic       regDstA[3];
    logic       regWriteA[3];
    logic [1:0] aluSrcBA[3];
    logic [1:0] pcSourceA[3];
    logic [1:0] aluOpA[3];
    logic       doneA[3];
    logic       illA[3];
    logic [3:0] stateA[3];

    int total = 0;
    int bad   = 0;

    step_t stim[$];

    always #5 clk = ~clk;

    // Instance 0: L=1 with extended ISA, 1: L=3 with extended ISA, 2: L=1 base ISA only.
    for (genvar g = 0; g < 3; g++) begin : gDut
        multicycle_control #(
            .MEM_LATENCY((g == 1) ? 3 : 1),
            .EXT_ISA    ((g == 2) ? 0 : 1)
        ) dut (
            .clk        (clk),
            .rst        (rst),
            .opcode     (opcode),
            .PCWrite    (pcWriteA[g]),
            .PCWriteCond(pcWriteCondA[g]),
            .IorD       (iorDA[g]),
            .MemRead    (memReadA[g]),
            .MemWrite   (memWriteA[g]),
            .MemtoReg   (memtoRegA[g]),
            .IRWrite    (irWriteA[g]),
            .ALUSrcA    (aluSrcAA[g]),
            .RegDst     (regDstA[g]),
            .RegWrite   (regWriteA[g]),
            .ALUSrcB    (aluSrcBA[g]),
            .PCSource   (pcSourceA[g]),
            .ALUOp      (aluOpA[g]),
            .instr_done (doneA[g]),
            .illegal_op (illA[g]),
            .state      (stateA[g])
        );
    end

    function automatic obs_t observe(input int k);
        obs_t o;
        o.st          = stateA[k];
        o.pcWrite     = pcWriteA[k];
        o.pcWriteCond = pcWriteCondA[k];
        o.iorD        = iorDA[k];
        o.memRead     = memReadA[k];
        o.memWrite    = memWriteA[k];
        o.memtoReg    = memtoRegA[k];
        o.irWrite     = irWriteA[k];
        o.aluSrcA     = aluSrcAA[k];
        o.regDst      = regDstA[k];
        o.regWrite    = regWriteA[k];
        o.aluSrcB     = aluSrcBA[k];
        o.pcSource    = pcSourceA[k];
        o.aluOp       = aluOpA[k];
        o.done        = doneA[k];
        o.ill         = illA[k];
        return o;
    endfunction

    task automatic checkVal(input string tag, input obs_t got, input obs_t exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h (state got=%0d exp=%0d)", tag, got, exp, got.st, exp.st);
        end
    endtask

    function automatic obs_t zeroAt(input logic [3:0] st);
        obs_t o;
        o    = '0;
        o.st = st;
        return o;
    endfunction

    task automatic add(input logic r, input logic [5:0] opc, input logic rnd, input obs_t e);
        step_t s;
        s.rstIn   = r;
        s.opc     = opc;
        s.randOpc = rnd;
        s.exp     = e;
        stim.push_back(s);
    endtask

    // n cycles with rst held, then the release cycle spent in RST_S.
    task automatic addReset(input int n);
        for (int i = 0; i < n; i++) add(1'b1, 6'd0, 1'b1, zeroAt(4'd0));
        add(1'b0, 6'd0, 1'b1, zeroAt(4'd0));
    endtask

    task automatic addFetch(input int lat);
        obs_t o;
        for (int i = 0; i < lat; i++) begin
            o         = zeroAt(4'd1);
            o.memRead = 1'b1;
            o.aluSrcB = 2'b01;
            o.aluOp   = 2'b10;
            if (i == lat - 1) begin
                o.irWrite = 1'b1;
                o.pcWrite = 1'b1;
            end
            add(1'b0, 6'd0, 1'b1, o);
        end
    endtask

    task automatic addDecode(input logic [5:0] opc, input logic illegal);
        obs_t o;
        o         = zeroAt(4'd2);
        o.aluSrcB = 2'b11;
        o.aluOp   = 2'b10;
        o.ill     = illegal;
        o.done    = illegal;
        add(1'b0, opc, 1'b0, o);
    endtask

    task automatic addMemAddr();
        obs_t o;
        o         = zeroAt(4'd3);
        o.aluSrcA = 1'b1;
        o.aluSrcB = 2'b10;
        o.aluOp   = 2'b10;
        add(1'b0, 6'd0, 1'b1, o);
    endtask

    // Expected per-cycle outputs for one whole instruction, from fetch to completion.
    task automatic pushInstr(input logic [5:0] opc, input int lat, input bit ext);
        obs_t o;
        addFetch(lat);
        if (opc == 6'b000000) begin
            addDecode(opc, 1'b0);
            o = zeroAt(4'd7); o.aluSrcA = 1'b1;
            add(1'b0, 6'd0, 1'b1, o);
            o = zeroAt(4'd8); o.regDst = 1'b1; o.regWrite = 1'b1; o.done = 1'b1;
            add(1'b0, 6'd0, 1'b1, o);
        end else if (opc == 6'b100011) begin
            addDecode(opc, 1'b0);
            addMemAddr();
            for (int i = 0; i < lat; i++) begin
                o = zeroAt(4'd4); o.memRead = 1'b1; o.iorD = 1'b1;
                add(1'b0, 6'd0, 1'b1, o);
            end
            o = zeroAt(4'd5); o.regWrite = 1'b1; o.memtoReg = 1'b1; o.done = 1'b1;
            add(1'b0, 6'd0, 1'b1, o);
        end else if (opc == 6'b101011) begin
            addDecode(opc, 1'b0);
            addMemAddr();
            for (int i = 0; i < lat; i++) begin
                o = zeroAt(4'd6); o.memWrite = 1'b1; o.iorD = 1'b1; o.done = (i == lat - 1);
                add(1'b0, 6'd0, 1'b1, o);
            end
        end else if (opc == 6'b000100) begin
            addDecode(opc, 1'b0);
            o = zeroAt(4'd9); o.aluSrcA = 1'b1; o.aluOp = 2'b01; o.pcWriteCond = 1'b1;
            o.pcSource = 2'b01; o.done = 1'b1;
            add(1'b0, 6'd0, 1'b1, o);
        end else if (opc == 6'b000010 && ext) begin
            addDecode(opc, 1'b0);
            o = zeroAt(4'd10); o.pcWrite = 1'b1; o.pcSource = 2'b10; o.done = 1'b1;
            add(1'b0, 6'd0, 1'b1, o);
        end else if (opc == 6'b001000 && ext) begin
            addDecode(opc, 1'b0);
            o = zeroAt(4'd11); o.aluSrcA = 1'b1; o.aluSrcB = 2'b10; o.aluOp = 2'b10;
            add(1'b0, 6'd0, 1'b1, o);
            o = zeroAt(4'd12); o.regWrite = 1'b1; o.done = 1'b1;
            add(1'b0, 6'd0, 1'b1, o);
        end else begin
            addDecode(opc, 1'b1);
        end
    endtask

    // Driver pushes the expectation as it drives; the monitor pops it 1ns later.
    task automatic runSteps(input int sel, input int phase);
        obs_t  expQ[$];
        step_t s;
        int    idx;
        idx = 0;
        while (stim.size() > 0) begin
            s = stim.pop_front();
            @(negedge clk);
            rst    = s.rstIn;
            opcode = s.randOpc ? 6'($urandom) : s.opc;
            expQ.push_back(s.exp);
            #1;
            checkVal($sformatf("ph%0d_cyc%0d", phase, idx), observe(sel), expQ.pop_front());
            idx++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        obs_t o;
        rst    = 1'b1;
        opcode = 6'd0;
        repeat (3) @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) checkVal($sformatf("reset_dut%0d", k), observe(k), zeroAt(4'd0));

        // L=1, extended ISA: every instruction class plus an unsupported opcode.
        addReset(2);
        pushInstr(6'b000000, 1, 1'b1);
        pushInstr(6'b100011, 1, 1'b1);
        pushInstr(6'b101011, 1, 1'b1);
        pushInstr(6'b000100, 1, 1'b1);
        pushInstr(6'b000010, 1, 1'b1);
        pushInstr(6'b001000, 1, 1'b1);
        pushInstr(6'b111111, 1, 1'b1);
        pushInstr(6'b000000, 1, 1'b1);
        runSteps(0, 0);

        // L=3: memory states stretch, others do not.
        addReset(3);
        pushInstr(6'b100011, 3, 1'b1);
        pushInstr(6'b101011, 3, 1'b1);
        pushInstr(6'b000000, 3, 1'b1);
        pushInstr(6'b000100, 3, 1'b1);
        pushInstr(6'b000010, 3, 1'b1);
        pushInstr(6'b001000, 3, 1'b1);
        pushInstr(6'b111111, 3, 1'b1);
        runSteps(1, 1);

        // Base ISA: addi and j must be rejected.
        addReset(2);
        pushInstr(6'b001000, 1, 1'b0);
        pushInstr(6'b000010, 1, 1'b0);
        pushInstr(6'b000000, 1, 1'b0);
        pushInstr(6'b100011, 1, 1'b0);
        runSteps(2, 2);

        // L=3 sw interrupted by reset during its second MEM_WRITE cycle.
        addReset(2);
        addFetch(3);
        addDecode(6'b101011, 1'b0);
        addMemAddr();
        o = zeroAt(4'd6); o.memWrite = 1'b1; o.iorD = 1'b1;
        add(1'b0, 6'd0, 1'b1, o);
        add(1'b1, 6'd0, 1'b1, zeroAt(4'd0));
        addReset(2);
        pushInstr(6'b000000, 3, 1'b1);
        runSteps(1, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
